// File: rtl/qpsk_frame_sync_if.sv
// qpsk_frame_sync_if -- symbol-in / byte-out stream bundle for the QPSK deframer.
//   dibit       demodulated symbol, dibit[1] is the earlier bit
//   dibit_vld   dibit qualifier, one dibit per high cycle
//   data_tdata  payload byte, first dibit in [7:6]
//   data_tvalid one-cycle pulse per byte, no backpressure
//   data_tuser  first byte of a frame
//   data_tlast  last byte of a frame
// master: demodulator/consumer side; slave: the deframer.
interface qpsk_frame_sync_if;
   logic [1:0] dibit;
   logic       dibit_vld;
   logic [7:0] data_tdata;
   logic       data_tvalid;
   logic       data_tuser;
   logic       data_tlast;

   modport master (output dibit, dibit_vld,
                   input  data_tdata, data_tvalid, data_tuser, data_tlast);
   modport slave  (input  dibit, dibit_vld,
                   output data_tdata, data_tvalid, data_tuser, data_tlast);
endinterface

// File: rtl/qpsk_frame_sync.sv
// qpsk_frame_sync -- receive-side QPSK deframer.
// Hunts for SYNC_WORD in the hard-decision dibit stream (up to MAX_ERR bit errors),
// then derotates and packs PAYLOAD_BYTES bytes onto the output stream.
// Optional feature macro: PHASE_RESOLVE_EN -- when defined, all four carrier-phase
// rotations of the sync word are tried and the payload is derotated by the matched k;
// otherwise only the unrotated sync is accepted and rot is tied to 0.
// Ports:
//   clk_1M024    symbol clock
//   rst_n_1M024  asynchronous reset, active low
//   en           block enable; low behaves like reset
//   s            stream bundle (slave modport)
//   locked       high while receiving payload
//   rot          rotation index of the matched sync
//   frame_cnt    completed frames, saturating
module qpsk_frame_sync #(
   parameter logic [31:0] SYNC_WORD     = 32'h1ACFFC1D,
   parameter int          PAYLOAD_BYTES = 16,
   parameter int          MAX_ERR       = 2
) (
   input  logic                 clk_1M024,
   input  logic                 rst_n_1M024,
   input  logic                 en,
   qpsk_frame_sync_if.slave     s,
   output logic                 locked,
   output logic [1:0]           rot,
   output logic [15:0]          frame_cnt
);
`ifdef PHASE_RESOLVE_EN
   localparam int NCAND = 4;
`else
   localparam int NCAND = 1;
`endif
   localparam logic [7:0] LAST = 8'(PAYLOAD_BYTES - 1);

   typedef enum logic {HUNT, PAYLOAD} state_t;

   // One quarter-turn of the carrier: R(b1,b0) = (b0,~b1)
   function automatic logic [1:0] rot_fwd(input logic [1:0] d);
      return {d[0], ~d[1]};
   endfunction

   function automatic logic [31:0] cand_word(input int k);
      logic [31:0] w;
      w = SYNC_WORD;
      for (int r = 0; r < k; r++)
         for (int i = 0; i < 16; i++)
            w[2*i +: 2] = rot_fwd(w[2*i +: 2]);
      return w;
   endfunction

   state_t      state;
   logic [29:0] hist;      // last 15 dibits; the current dibit completes the window
   logic [31:0] window;
   logic [5:0]  part;      // earlier dibits of the byte being packed
   logic [1:0]  dcnt;
   logic [7:0]  bcnt;
   logic [1:0]  dr;        // derotated dibit
   logic        hit;

   assign window = {hist, s.dibit};

`ifdef PHASE_RESOLVE_EN
   logic [1:0] hit_k;
   logic [1:0] rot_r;

   // Inverse quarter-turn: R'(b1,b0) = (~b0,b1)
   function automatic logic [1:0] rot_inv(input logic [1:0] d);
      return {~d[0], d[1]};
   endfunction

   // Descending scan so the lowest matching k wins.
   always_comb begin
      hit   = 1'b0;
      hit_k = 2'd0;
      for (int k = NCAND - 1; k >= 0; k--)
         if ($countones(window ^ cand_word(k)) <= MAX_ERR) begin
            hit   = 1'b1;
            hit_k = 2'(k);
         end
   end

   always_comb begin
      dr = s.dibit;
      for (int i = 0; i < 3; i++)
         if (i < int'(rot_r)) dr = rot_inv(dr);
   end

   assign rot = rot_r;
`else
   always_comb begin
      hit = 1'b0;
      for (int k = 0; k < NCAND; k++)
         if ($countones(window ^ cand_word(k)) <= MAX_ERR) hit = 1'b1;
   end

   assign dr  = s.dibit;
   assign rot = 2'b00;
`endif

   always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
      if (!rst_n_1M024) begin
         state         <= HUNT;
         hist          <= '0;
         part          <= '0;
         dcnt          <= '0;
         bcnt          <= '0;
         locked        <= 1'b0;
         frame_cnt     <= '0;
         s.data_tdata  <= '0;
         s.data_tvalid <= 1'b0;
         s.data_tuser  <= 1'b0;
         s.data_tlast  <= 1'b0;
`ifdef PHASE_RESOLVE_EN
         rot_r         <= 2'd0;
`endif
      end else if (!en) begin
         state         <= HUNT;
         hist          <= '0;
         part          <= '0;
         dcnt          <= '0;
         bcnt          <= '0;
         locked        <= 1'b0;
         frame_cnt     <= '0;
         s.data_tdata  <= '0;
         s.data_tvalid <= 1'b0;
         s.data_tuser  <= 1'b0;
         s.data_tlast  <= 1'b0;
`ifdef PHASE_RESOLVE_EN
         rot_r         <= 2'd0;
`endif
      end else begin
         // Byte strobes are single-cycle regardless of dibit_vld.
         s.data_tvalid <= 1'b0;
         s.data_tuser  <= 1'b0;
         s.data_tlast  <= 1'b0;
         if (s.dibit_vld) begin
            case (state)
               HUNT: begin
                  hist <= window[29:0];
                  if (hit) begin
                     state  <= PAYLOAD;
                     locked <= 1'b1;
                     dcnt   <= '0;
                     bcnt   <= '0;
`ifdef PHASE_RESOLVE_EN
                     rot_r  <= hit_k;
`endif
                  end
               end
               PAYLOAD: begin
                  dcnt <= dcnt + 2'd1;
                  part <= {part[3:0], dr};
                  if (dcnt == 2'd3) begin
                     s.data_tdata  <= {part, dr};
                     s.data_tvalid <= 1'b1;
                     s.data_tuser  <= (bcnt == 8'd0);
                     s.data_tlast  <= (bcnt == LAST);
                     bcnt          <= bcnt + 8'd1;
                     if (bcnt == LAST) begin
                        // Next sync must arrive in full: history restarts from zero.
                        state  <= HUNT;
                        locked <= 1'b0;
                        hist   <= '0;
                        if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_qpsk_frame_sync.sv
module tb_qpsk_frame_sync;
   localparam logic [31:0] SYNC = 32'h1ACFFC1D;
   localparam int PB   = 16;
   localparam int MAXE = 2;
`ifdef PHASE_RESOLVE_EN
   localparam int NK = 4;
`else
   localparam int NK = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        locked;
   logic [1:0]  rot;
   logic [15:0] frame_cnt;

   qpsk_frame_sync_if bus ();

   qpsk_frame_sync #(.SYNC_WORD(SYNC), .PAYLOAD_BYTES(PB), .MAX_ERR(MAXE)) dut (
      .clk_1M024   (clk),
      .rst_n_1M024 (rst_n),
      .en          (en),
      .s           (bus),
      .locked      (locked),
      .rot         (rot),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] d;
      logic       u;
      logic       l;
      int         c;
   } ev_t;

   ev_t        got_q[$];
   ev_t        exp_q[$];
   logic [1:0] sent_d[$];
   int         sent_c[$];
   logic [7:0] payload [PB];
   int         tests = 0;
   int         fails = 0;
   int         exp_fc;
   logic       exp_lk;
   logic [1:0] exp_rot;

   // Carrier phase as a position on the Gray cycle 00->01->11->10; one quarter-turn = +1.
   function automatic int phase_of(input logic [1:0] d);
      case (d)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] turn(input logic [1:0] d, input int k);
      logic [1:0] tbl [4];
      tbl = '{2'b00, 2'b01, 2'b11, 2'b10};
      return tbl[(phase_of(d) + k + 8) % 4];
   endfunction

   function automatic logic [31:0] turn_word(input logic [31:0] w, input int k);
      logic [31:0] r;
      for (int i = 0; i < 16; i++) r[2*i +: 2] = turn(w[2*i +: 2], k);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk)
      if (rst_n && en && bus.data_tvalid)
         got_q.push_back('{bus.data_tdata, bus.data_tuser, bus.data_tlast, cyc});

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      en = 1'b0;
      bus.dibit = 2'b00;
      bus.dibit_vld = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      en = 1'b1;
      got_q.delete();
      sent_d.delete();
      sent_c.delete();
   endtask

   task automatic send_dibit(input logic [1:0] d, input int gap);
      repeat (gap) begin
         @(negedge clk);
         bus.dibit_vld = 1'b0;
         bus.dibit = 2'($urandom);
      end
      @(negedge clk);
      bus.dibit = d;
      bus.dibit_vld = 1'b1;
      sent_d.push_back(d);
      sent_c.push_back(cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.dibit_vld = 1'b0;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int k, input int gap);
      for (int i = 15; i >= 0; i--) send_dibit(turn(w[2*i +: 2], k), gap);
   endtask

   task automatic send_byte(input logic [7:0] b, input int k, input int gap);
      for (int i = 3; i >= 0; i--) send_dibit(turn(b[2*i +: 2], k), gap);
   endtask

   task automatic send_payload(input int k, input int gap);
      for (int b = 0; b < PB; b++) send_byte(payload[b], k, gap);
   endtask

   task automatic rand_payload();
      for (int b = 0; b < PB; b++) payload[b] = 8'($urandom);
   endtask

   // Reference: slide a 16-dibit window over the accepted dibits, lock on the first
   // window within MAXE bits of any allowed rotation, then cut the next 4*PB dibits
   // into bytes, undoing the rotation.
   task automatic model();
      int         n, i, hs, kh, f;
      logic [31:0] w;
      logic [7:0] v;
      n = sent_d.size();
      i = 0;
      hs = 0;
      exp_q.delete();
      exp_fc = 0;
      exp_lk = 1'b0;
      exp_rot = 2'd0;
      while (i < n) begin
         w = '0;
         for (int j = i - 15; j <= i; j++) w = {w[29:0], (j >= hs) ? sent_d[j] : 2'b00};
         kh = -1;
         for (int k = NK - 1; k >= 0; k--)
            if ($countones(w ^ turn_word(SYNC, k)) <= MAXE) kh = k;
         if (kh < 0) begin
            i++;
         end else begin
            exp_rot = 2'(kh);
            exp_lk = 1'b1;
            for (int b = 0; b < PB; b++) begin
               f = i + 1 + 4 * b;
               if (f + 3 >= n) break;
               for (int q = 0; q < 4; q++) v = {v[5:0], turn(sent_d[f+q], 4 - kh)};
               exp_q.push_back('{v, b == 0, b == PB - 1, sent_c[f+3] + 1});
            end
            if (i + 4 * PB < n) begin
               exp_fc++;
               exp_lk = 1'b0;
               hs = i + 4 * PB + 1;
               i = hs;
            end else begin
               i = n;
            end
         end
      end
   endtask

   task automatic finish_scn(input string tag);
      int m;
      idle(6);
      model();
      chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
      m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) begin
         chk($sformatf("%s_byte%0d", tag, i), got_q[i].d, exp_q[i].d);
         chk($sformatf("%s_flags%0d", tag, i), {got_q[i].u, got_q[i].l}, {exp_q[i].u, exp_q[i].l});
         chk($sformatf("%s_time%0d", tag, i), got_q[i].c, exp_q[i].c);
      end
      chk({tag, "_frame_cnt"}, frame_cnt, exp_fc);
      chk({tag, "_locked"}, locked, exp_lk);
      chk({tag, "_rot"}, rot, exp_rot);
   endtask

   int e1, e2, nu, nl;

   initial begin
      bus.dibit = 2'b00;
      bus.dibit_vld = 1'b0;

      // Reset state
      do_reset();
      chk("reset_outs", {bus.data_tdata, bus.data_tvalid, bus.data_tuser, bus.data_tlast,
                         locked, rot, frame_cnt}, 30'd0);

      // 1: clean frame, counting payload
      for (int b = 0; b < PB; b++) payload[b] = 8'(b);
      send_word(SYNC, 0, 0);
      send_payload(0, 0);
      finish_scn("t1");
      chk("t1_fc_abs", frame_cnt, 16'd1);
      chk("t1_cnt_abs", got_q.size(), PB);
      if (got_q.size() == PB) begin
         chk("t1_first", {got_q[0].d, got_q[0].u, got_q[0].l}, {8'h00, 2'b10});
         chk("t1_last", {got_q[PB-1].d, got_q[PB-1].u, got_q[PB-1].l}, {8'h0F, 2'b01});
      end

      // 2: whole frame rotated two quarter-turns
      do_reset();
      rand_payload();
      send_word(SYNC, 2, 0);
      send_payload(2, 0);
      finish_scn("t2");
      chk("t2_fc_abs", frame_cnt, (NK == 4) ? 16'd1 : 16'd0);
      chk("t2_rot_abs", rot, (NK == 4) ? 2'd2 : 2'd0);

      // 3a: two bit errors in sync still lock
      do_reset();
      rand_payload();
      e1 = $urandom_range(31);
      e2 = (e1 + 1 + $urandom_range(30)) % 32;
      send_word(SYNC ^ (32'd1 << e1) ^ (32'd1 << e2), 0, 0);
      send_payload(0, 0);
      finish_scn("t3a");
      chk("t3a_fc_abs", frame_cnt, 16'd1);

      // 3b: three bit errors never lock
      do_reset();
      rand_payload();
      e1 = $urandom_range(31);
      send_word(SYNC ^ (32'd1 << e1) ^ (32'd1 << ((e1 + 11) % 32)) ^ (32'd1 << ((e1 + 21) % 32)), 0, 0);
      send_payload(0, 0);
      finish_scn("t3b");
      chk("t3b_locked_abs", locked, 1'b0);
      chk("t3b_cnt_abs", got_q.size(), 0);

      // 4: dibit_vld low 3 of every 4 cycles, with leading noise
      do_reset();
      rand_payload();
      for (int i = 0; i < 5; i++) send_dibit(2'($urandom), 3);
      send_word(SYNC, 0, 3);
      send_payload(0, 3);
      finish_scn("t4");
      chk("t4_fc_abs", frame_cnt, 16'd1);

      // 5: async reset right after byte 5, then a fresh frame
      do_reset();
      rand_payload();
      send_word(SYNC, 0, 0);
      for (int b = 0; b < 6; b++) send_byte(payload[b], 0, 0);
      @(negedge clk);
      bus.dibit_vld = 1'b0;
      chk("t5_pre_rst", {bus.data_tvalid, locked}, 2'b11);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_async_rst", {bus.data_tdata, bus.data_tvalid, bus.data_tuser, bus.data_tlast,
                           locked, rot, frame_cnt}, 30'd0);
      do_reset();
      rand_payload();
      send_word(SYNC, 0, 0);
      send_payload(0, 0);
      finish_scn("t5");
      chk("t5_fc_abs", frame_cnt, 16'd1);

      // 6: payload carries the sync word; two frames back to back
      do_reset();
      rand_payload();
      payload[4] = 8'h1A; payload[5] = 8'hCF; payload[6] = 8'hFC; payload[7] = 8'h1D;
      send_word(SYNC, 0, 0);
      send_payload(0, 0);
      send_word(SYNC, 0, 0);
      send_payload(0, 0);
      finish_scn("t6");
      nu = 0;
      nl = 0;
      foreach (got_q[i]) begin
         nu += int'(got_q[i].u);
         nl += int'(got_q[i].l);
      end
      chk("t6_fc_abs", frame_cnt, 16'd2);
      chk("t6_tuser_cnt", nu, 2);
      chk("t6_tlast_cnt", nl, 2);

      // 7: en dropped mid-frame clears everything; the next frame counts from 0
      do_reset();
      rand_payload();
      send_word(SYNC, 0, 0);
      for (int b = 0; b < 3; b++) send_byte(payload[b], 0, 0);
      @(negedge clk);
      bus.dibit_vld = 1'b0;
      en = 1'b0;
      @(negedge clk);
      chk("t7_en_low", {bus.data_tdata, bus.data_tvalid, bus.data_tuser, bus.data_tlast,
                        locked, rot, frame_cnt}, 30'd0);
      en = 1'b1;
      got_q.delete();
      sent_d.delete();
      sent_c.delete();
      rand_payload();
      send_word(SYNC, 0, 0);
      send_payload(0, 0);
      finish_scn("t7");
      chk("t7_fc_abs", frame_cnt, 16'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
